cs_sync_fifo: RTL

//   Synchronous FIFO with chip-select write/read ports. It is the design side that the

---
 rtl/cs_fifo_pkg.sv | 18 +
 rtl/cs_fifo_ram.sv | 33 +++
 rtl/cs_sync_fifo.sv | 117 +++++++++++
 3 files changed

// File: rtl/cs_fifo_pkg.sv
// rtl/cs_fifo_pkg.sv - shared constants and helpers for the chip-select FIFO
package cs_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_fifo_ram.sv
// rtl/cs_fifo_ram.sv - simple dual-port storage with registered read port
module cs_fifo_ram
    import cs_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset; the read register only moves on re.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cs_sync_fifo.sv
// rtl/cs_sync_fifo.sv - synchronous FIFO with chip-select ports and sticky error flags
module cs_sync_fifo
    import cs_fifo_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_cs,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_cs,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             wr_err,
    output logic             rd_err,
    input  logic             err_clr
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_err_q, wr_err_d;
    logic             rd_err_q, rd_err_d;
    logic             dout_vld_q, dout_vld_d;
    logic             wr_req, rd_req;
    logic             wr_go, rd_go;
    logic [WIDTH-1:0] ram_rdata;

    assign wr_req = wr_cs & wr_en;
    assign rd_req = rd_cs & rd_en;
    assign wr_go  = wr_req & ~full_q;
    assign rd_go  = rd_req & ~empty_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_vld_d = dout_vld_q;

        if (wr_go) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_go) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            dout_vld_d = 1'b1;
        end

        case ({wr_go, rd_go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);

        // A new violation in the same cycle as err_clr must stay visible.
        wr_err_d = (wr_err_q & ~err_clr) | (wr_req & full_q);
        rd_err_d = (rd_err_q & ~err_clr) | (rd_req & empty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            dout_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            wr_err_q   <= wr_err_d;
            rd_err_q   <= rd_err_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    cs_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_go),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_go),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset, so dout is forced to zero until
    // the first accepted read after reset loads it.
    assign dout   = dout_vld_q ? ram_rdata : '0;
    assign full   = full_q;
    assign empty  = empty_q;
    assign count  = count_q;
    assign wr_err = wr_err_q;
    assign rd_err = rd_err_q;

endmodule
